addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Operand sequencer and result stage for the 8-bit adder-subtractor datapath.
- Accepts operation requests over a valid/ready handshake and computes add or subtract, with an optional running-accumulator operand.
- Attaches carry/borrow, overflow, zero and negative flags to each result.
- Buffers results in a small FIFO for a downstream consumer with its own valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DEPTH, 4, result FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  request can be accepted this cycle.
- in_a  input  WIDTH  operand A; ignored when in_acc=1.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1: A-B, 0: A+B.
- in_acc  input  1  1: operand A is the internal accumulator.
- in_clr  input  1  1: clear the accumulator to 0 after this op completes.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer takes the head this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  add: carry out; sub: borrow (unsigned A<B).
- out_ovf  output  1  two's-complement signed overflow.
- out_zero  output  1  out_sum == 0.
- out_neg  output  1  out_sum MSB.
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state: FIFO empty, count=0, accumulator=0, out_valid=0.
- Output values at and after reset: out_sum, out_carry, out_ovf, out_zero and out_neg are 0. in_ready=0 during any cycle with reset=1, then 1 on the first cycle after reset is released.
- Data gating: out_* data are forced to 0 whenever out_valid=0.
- Reset mid-operation: pending FIFO entries are discarded and the accumulator clears. A request presented in a reset cycle is not accepted.
- in_ready = !reset && (count < DEPTH). It is not a function of out_ready: no push while full, even if a pop occurs in the same cycle.
- Accept: fires when in_valid && in_ready. The operation is computed combinationally in the same cycle from A (in_a, or the accumulator when in_acc=1), in_b and in_sub. The result and flags are written at the FIFO tail on that edge.
- Latency: a result is visible at out_* the cycle after acceptance if the FIFO was empty. Throughput is 1 op/cycle while not full.
- Accumulator update on accept: if in_clr=1, acc <= 0. Otherwise acc <= computed sum. Within one request, in_acc reads the old accumulator value before the update.
- Arithmetic: computed at WIDTH+1 bits.
  - Add: {carry,sum} = A+B.
  - Sub: {x,sum} = A + ~B + 1; out_carry = ~x (borrow).
  - Add overflow: A and B have the same sign and sum's sign differs.
  - Sub overflow: A and B have different signs and sum's sign differs from A.
- Pop: fires when out_valid && out_ready. The head advances on that edge. out_ready while empty is ignored.
- Simultaneous push and pop (not full): count unchanged, pointers both advance. When count=1 with push and pop together, the new entry is at the head the next cycle and out_valid stays 1.
- Pointers: wrap modulo DEPTH. count saturates structurally (no push at DEPTH, no pop at 0).
- FIFO storage: plain registers; no output skid.

Decomposition:
- Shared package (addsub_pkg): WIDTH default; DEPTH default; a flag-vector typedef {carry, ovf, zero, neg} with named bit-index constants; the result-entry typedef {sum, flags}.
- Sub-module addsub_core: purely combinational WIDTH-bit add/sub producing sum, carry/borrow and overflow. addsub_seq instantiates it once.
- FIFO and accumulator logic stay inline in addsub_seq.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, all out_* = 0, count=0.
- Add 0x7F+0x01 with out_ready=1 -> next cycle: out_sum=0x80, ovf=1, neg=1, carry=0, zero=0. Then sub 0x10-0x20 -> out_sum=0xF0, carry(borrow)=1, ovf=0, neg=1.
- Accumulate: three back-to-back requests with in_acc=1, in_sub=0, B=0x05, 0x05, 0xFA -> results 0x05, 0x0A, 0x04 with carry=1 on the third. Then in_clr=1 with in_acc=1, B=0x03 -> result 0x07; a following in_acc=1, B=0x01 -> 0x01.
- Backpressure: out_ready=0 with 6 requests offered at DEPTH=4 -> 4 accepted, in_ready=0 and count=4. Release out_ready -> results drain in order. in_ready rises the cycle after the first pop, and the remaining 2 are accepted without loss.
- Simultaneous push and pop at count=1 -> count stays 1 and the output sequence is preserved. Sub 0x05-0x05 -> zero=1, carry=0.
- Reset asserted with 3 entries queued and in_valid=1 -> the following cycle: count=0, out_valid=0, accumulator=0, and no request accepted during the reset cycle.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared widths, flag layout and result-entry type for the adder-subtractor
// sequencer and its combinational core.
package addsub_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bit positions inside a flag vector.
  localparam int FLAG_W     = 4;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    flags_t               flags;
  } entry_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder-subtractor producing sum, carry/borrow and
// two's-complement overflow.
module addsub_core #(
  parameter int WIDTH = addsub_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   ext;

  // Subtraction is A + ~B + 1; the extra bit is an inverted borrow.
  assign b_eff = sub ? ~b : b;
  assign ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = ext[WIDTH-1:0];
  assign carry = sub ? ~ext[WIDTH] : ext[WIDTH];

  // Overflow when the effective operands agree in sign and the result does not.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_seq.sv
// Operand sequencer with running accumulator and a result FIFO feeding a
// valid/ready consumer.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic                   in_sub,
  input  logic                   in_acc,
  input  logic                   in_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_sum,
  output logic                   out_carry,
  output logic                   out_ovf,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  flags_t           new_flags;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] sum_mem  [DEPTH];
  flags_t           flag_mem [DEPTH];

  assign op_a = in_acc ? acc : in_a;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (op_a),
    .b    (in_b),
    .sub  (in_sub),
    .sum  (sum),
    .carry(carry),
    .ovf  (ovf)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    new_flags             = '0;
    new_flags[FLAG_CARRY] = carry;
    new_flags[FLAG_OVF]   = ovf;
    new_flags[FLAG_ZERO]  = (sum == '0);
    new_flags[FLAG_NEG]   = sum[WIDTH-1];
  end

  // Readiness ignores out_ready: a full FIFO never pushes, even on a pop cycle.
  assign in_ready  = !reset && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignment so all registers
  // update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        acc    <= in_clr ? '0 : sum;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never exposed
  // because the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr]  <= sum;
      flag_mem[wr_ptr] <= new_flags;
    end
  end

  always_comb begin
    out_sum   = '0;
    out_carry = 1'b0;
    out_ovf   = 1'b0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    if (out_valid) begin
      out_sum   = sum_mem[rd_ptr];
      out_carry = flag_mem[rd_ptr][FLAG_CARRY];
      out_ovf   = flag_mem[rd_ptr][FLAG_OVF];
      out_zero  = flag_mem[rd_ptr][FLAG_ZERO];
      out_neg   = flag_mem[rd_ptr][FLAG_NEG];
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed scenarios plus random traffic,
// compared each cycle against a queue-based arithmetic reference model.
module tb_addsub_seq;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         acc;
    logic         clr;
  } req_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_acc;
  logic         in_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;
  logic         out_neg;
  logic [2:0]   count;

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  res_t mq[$];
  int   m_acc = 0;
  bit   last_push;

  addsub_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_acc   (in_acc),
    .in_clr   (in_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_zero (out_zero),
    .out_neg  (out_neg),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic from plain integer math on unsigned and signed views.
  function automatic res_t ref_op(input int a, input int b, input bit sub);
    res_t r;
    int full, sa, sb, sr;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    if (sub) begin
      full    = a - b;
      r.carry = (a < b);
      sr      = sa - sb;
    end else begin
      full    = a + b;
      r.carry = (full >= 2**W);
      sr      = sa + sb;
    end
    r.sum  = W'(full);
    r.ovf  = (sr >= 2**(W-1)) || (sr < -(2**(W-1)));
    r.zero = (r.sum == 0);
    r.neg  = (int'(r.sum) >= 2**(W-1));
    return r;
  endfunction

  task automatic check_outputs();
    res_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    check("out_valid", out_valid, mq.size() > 0);
    check("count", count, mq.size());
    check("out_sum", out_sum, h.sum);
    check("out_carry", out_carry, h.carry);
    check("out_ovf", out_ovf, h.ovf);
    check("out_zero", out_zero, h.zero);
    check("out_neg", out_neg, h.neg);
  endtask

  // One clock: inputs already driven; predict, clock, update model, compare.
  task automatic cycle();
    bit   m_ready, do_push, do_pop;
    res_t r;
    #1;
    m_ready = !reset && (mq.size() < DEPTH);
    do_push = in_valid && m_ready;
    do_pop  = (mq.size() > 0) && out_ready;
    check("in_ready", in_ready, m_ready);
    r = ref_op(in_acc ? m_acc : int'(in_a), int'(in_b), in_sub);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_acc = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(r);
        m_acc = in_clr ? 0 : int'(r.sum);
      end
    end
    last_push = do_push;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input req_t q, input bit ordy);
    in_valid  = v;
    in_a      = q.a;
    in_b      = q.b;
    in_sub    = q.sub;
    in_acc    = q.acc;
    in_clr    = q.clr;
    out_ready = ordy;
  endtask

  initial begin
    req_t bp[6];
    int   idx;

    reset = 1'b1;
    drive(1'b1, '{a: 8'h11, b: 8'h22, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b1);
    @(negedge clk);
    cycle();
    cycle();

    // Idle after reset.
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    cycle();

    // Signed overflow on add, then borrow on subtract (also clears the accumulator).
    drive(1'b1, '{a: 8'h7F, b: 8'h01, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b1);
    cycle();
    check("add7f_sum", out_sum, 8'h80);
    check("add7f_ovf", out_ovf, 1'b1);
    drive(1'b1, '{a: 8'h10, b: 8'h20, sub: 1'b1, acc: 1'b0, clr: 1'b1}, 1'b1);
    cycle();
    check("sub10_sum", out_sum, 8'hF0);
    check("sub10_borrow", out_carry, 1'b1);

    // Accumulate chain, clear, restart.
    drive(1'b1, '{a: 8'h00, b: 8'h05, sub: 1'b0, acc: 1'b1, clr: 1'b0}, 1'b1);
    cycle();
    drive(1'b1, '{a: 8'h00, b: 8'h05, sub: 1'b0, acc: 1'b1, clr: 1'b0}, 1'b1);
    cycle();
    check("acc2_sum", out_sum, 8'h0A);
    drive(1'b1, '{a: 8'h00, b: 8'hFA, sub: 1'b0, acc: 1'b1, clr: 1'b0}, 1'b1);
    cycle();
    check("acc3_sum", out_sum, 8'h04);
    check("acc3_carry", out_carry, 1'b1);
    drive(1'b1, '{a: 8'h00, b: 8'h03, sub: 1'b0, acc: 1'b1, clr: 1'b1}, 1'b1);
    cycle();
    check("accclr_sum", out_sum, 8'h07);
    drive(1'b1, '{a: 8'h00, b: 8'h01, sub: 1'b0, acc: 1'b1, clr: 1'b0}, 1'b1);
    cycle();
    check("accnew_sum", out_sum, 8'h01);
    drive(1'b0, '0, 1'b1);
    cycle();

    // Backpressure: six offered against a four-entry FIFO.
    for (int k = 0; k < 6; k++) bp[k] = '{a: W'(8'h10 * k + 3), b: W'(k + 1), sub: k[0], acc: 1'b0, clr: 1'b0};
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, bp[idx], 1'b0);
      cycle();
      if (last_push) idx++;
    end
    check("bp_full_count", count, 3'd4);
    check("bp_full_ready", in_ready, 1'b0);
    for (int c = 0; c < 20 && (idx < 6 || mq.size() > 0); c++) begin
      drive(idx < 6, bp[idx < 6 ? idx : 0], 1'b1);
      cycle();
      if (last_push) idx++;
    end
    check("bp_drained", count, 3'd0);

    // Push and pop together at count=1, then equal-operand subtract.
    drive(1'b1, '{a: 8'h21, b: 8'h02, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b0);
    cycle();
    drive(1'b1, '{a: 8'h40, b: 8'h03, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b1);
    cycle();
    check("pp_count", count, 3'd1);
    check("pp_head", out_sum, 8'h43);
    drive(1'b1, '{a: 8'h05, b: 8'h05, sub: 1'b1, acc: 1'b0, clr: 1'b0}, 1'b1);
    cycle();
    check("sub_eq_zero", out_zero, 1'b1);
    check("sub_eq_borrow", out_carry, 1'b0);
    drive(1'b0, '0, 1'b1);
    cycle();

    // Reset with three entries queued and a request on the input.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, '{a: W'(8'h30 + k), b: 8'h01, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b0);
      cycle();
    end
    reset = 1'b1;
    drive(1'b1, '{a: 8'h55, b: 8'h01, sub: 1'b0, acc: 1'b0, clr: 1'b0}, 1'b0);
    cycle();
    check("rst_count", count, 3'd0);
    check("rst_valid", out_valid, 1'b0);
    reset = 1'b0;
    drive(1'b1, '{a: 8'h00, b: 8'h11, sub: 1'b0, acc: 1'b1, clr: 1'b0}, 1'b0);
    cycle();
    check("rst_acc_zero", out_sum, 8'h11);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = 1'($urandom);
      in_acc    = 1'($urandom);
      in_clr    = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
